// File: rtl/pbtn_debounce_if.sv
// Push-button conditioner bundle: raw pads and clears in, debounced level/strobes/flags out.
// The master drives the pads and clears; the slave (pbtn_debounce) drives the conditioned outputs.
interface pbtn_debounce_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] i_event_clr;
  logic [N_BTN-1:0] o_btn;
  logic [N_BTN-1:0] o_press;
  logic [N_BTN-1:0] o_release;
  logic [N_BTN-1:0] o_event;
  logic [N_BTN-1:0] o_long;
  logic             o_irq;

  modport master (
    output i_btn, i_event_clr,
    input  o_btn, o_press, o_release, o_event, o_long, o_irq
  );

  modport slave (
    input  i_btn, i_event_clr,
    output o_btn, o_press, o_release, o_event, o_long, o_irq
  );
endinterface

// File: rtl/pbtn_debounce.sv
// Per-button 2-flop synchroniser, stability-counter debouncer, press/release strobes, sticky flags and irq.
// Optional long-press strobe is built only when PBTN_LONGPRESS_EN is defined.
module pbtn_debounce #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  pbtn_debounce_if.slave bus
);
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]            meta_q, meta_d, sync_q, sync_d;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_BTN-1:0]            btn_q, btn_d;
  logic [N_BTN-1:0]            press_q, press_d, release_q, release_d;
  logic [N_BTN-1:0]            event_q, event_d;
  logic                        irq_q, irq_d;

  // Qualification: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    meta_d    = bus.i_btn;
    sync_d    = meta_q;
    cnt_d     = '0;
    btn_d     = btn_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync_q[i] != btn_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          btn_d[i]     = sync_q[i];
          press_d[i]   = sync_q[i];
          release_d[i] = ~sync_q[i];
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    event_d = (event_q & ~bus.i_event_clr) | press_d;
    irq_d   = |event_d;
  end

  // Core state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      cnt_q     <= '0;
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      event_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      event_q   <= event_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.o_btn     = btn_q;
  assign bus.o_press   = press_q;
  assign bus.o_release = release_q;
  assign bus.o_event   = event_q;
  assign bus.o_irq     = irq_q;

`ifdef PBTN_LONGPRESS_EN
  localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

  logic [N_BTN-1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [N_BTN-1:0]             long_q, long_d;

  // Hold counter saturates at LONG_CYCLES so the strobe fires once per press.
  always_comb begin
    hold_d = '0;
    long_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!btn_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != HOLD_MAX) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
      end else begin
        hold_d[i] = hold_q[i];
      end
      long_d[i] = (hold_d[i] == HOLD_FIRE) && (hold_q[i] != HOLD_FIRE);
    end
  end

  // Long-press state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q <= '0;
      long_q <= '0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign bus.o_long = long_q;
`else
  // Feature absent: the strobe is constant zero whatever LONG_CYCLES is set to.
  assign bus.o_long = (LONG_CYCLES > 0) ? '0 : '0;
`endif
endmodule

// File: tb/tb_pbtn_debounce.sv
// Self-checking bench: directed scenarios plus random bouncing, checked each cycle against a window-history model.
module tb_pbtn_debounce;
  localparam int NB   = 5;
  localparam int DB   = 8;
  localparam int LONG = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pbtn_debounce_if #(.N_BTN(NB)) bus ();

  pbtn_debounce #(.N_BTN(NB), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: raw pad value sampled at each edge since reset release.
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_btn, m_press, m_rel, m_event, m_long;
  logic          m_irq;
  int            press_at[NB];

  function automatic logic hv(int k, int b);
    if (k < 0) return 1'b0;
    return hist[k][b];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("o_btn",     32'(bus.o_btn),     32'(m_btn));
    chk("o_press",   32'(bus.o_press),   32'(m_press));
    chk("o_release", 32'(bus.o_release), 32'(m_rel));
    chk("o_event",   32'(bus.o_event),   32'(m_event));
    chk("o_irq",     32'(bus.o_irq),     32'(m_irq));
    chk("o_long",    32'(bus.o_long),    32'(m_long));
  endtask

  task automatic model_reset();
    hist.delete();
    m_btn = '0; m_press = '0; m_rel = '0; m_event = '0; m_long = '0; m_irq = 1'b0;
    for (int b = 0; b < NB; b++) press_at[b] = -1000;
  endtask

  // One clock: pads must sit unchanged for the DB samples taken 2..DB+1 edges ago to flip a level.
  task automatic tick();
    logic [NB-1:0] clr_s;
    int            e;
    bit            all;
    clr_s = bus.i_event_clr;
    hist.push_back(bus.i_btn);
    e = hist.size() - 1;
    @(posedge clk);
    m_press = '0; m_rel = '0; m_long = '0;
    for (int b = 0; b < NB; b++) begin
      all = 1'b1;
      for (int k = e - DB - 1; k <= e - 2; k++)
        if (hv(k, b) == m_btn[b]) all = 1'b0;
      if (all) begin
        m_btn[b] = ~m_btn[b];
        if (m_btn[b]) begin
          m_press[b]  = 1'b1;
          press_at[b] = e;
        end else begin
          m_rel[b] = 1'b1;
        end
      end
`ifdef PBTN_LONGPRESS_EN
      if (m_btn[b] && (e - press_at[b] == LONG - 1)) m_long[b] = 1'b1;
`endif
    end
    m_event = (m_event & ~clr_s) | m_press;
    m_irq   = |m_event;
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int rem[NB];
  int longs;

  initial begin
    bus.i_btn       = 5'h1F;
    bus.i_event_clr = 5'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_all();
    @(negedge clk);
    rst = 1'b0;

    // Held buttons re-qualify from zero after reset.
    repeat (9) tick();
    chk("s1_not_yet", 32'(bus.o_btn), 32'h0);
    tick();
    chk("s1_btn", 32'(bus.o_btn), 32'h1F);
    chk("s1_press", 32'(bus.o_press), 32'h1F);
    tick();
    chk("s1_press_done", 32'(bus.o_press), 32'h0);

    bus.i_btn = 5'h00;
    bus.i_event_clr = 5'h1F;
    tick();
    bus.i_event_clr = 5'h00;
    repeat (12) tick();
    chk("s1_event_cleared", 32'(bus.o_event), 32'h0);

    // Clean press on button 0.
    bus.i_btn = 5'h01;
    repeat (10) tick();
    chk("s2_press", 32'(bus.o_press), 32'h01);
    chk("s2_irq", 32'(bus.o_irq), 32'h1);
    tick();
    chk("s2_press_low", 32'(bus.o_press), 32'h0);

    // Bounce on button 2: toggles every 3 cycles, then holds.
    for (int i = 0; i < 10; i++) begin
      bus.i_btn[2] = ~bus.i_btn[2];
      repeat (3) tick();
    end
    bus.i_btn[2] = 1'b1;
    repeat (9) tick();
    chk("s3_no_early", 32'(bus.o_btn[2]), 32'h0);
    tick();
    chk("s3_press", 32'(bus.o_press), 32'h04);

    // Clear coinciding with a new press of button 0 loses nothing.
    bus.i_btn[0] = 1'b0;
    repeat (12) tick();
    bus.i_event_clr = 5'h01;
    tick();
    bus.i_event_clr = 5'h00;
    bus.i_btn[0] = 1'b1;
    repeat (9) tick();
    bus.i_event_clr = 5'h01;
    tick();
    bus.i_event_clr = 5'h00;
    chk("s4_set_wins", 32'(bus.o_event[0]), 32'h1);
    bus.i_event_clr = 5'h05;
    tick();
    bus.i_event_clr = 5'h00;
    chk("s4_cleared", 32'(bus.o_event), 32'h0);
    chk("s4_irq_low", 32'(bus.o_irq), 32'h0);

    // Simultaneous release of buttons 1 and 3.
    bus.i_btn = 5'h0B;
    repeat (12) tick();
    bus.i_btn = 5'h01;
    repeat (10) tick();
    chk("s5_release", 32'(bus.o_release), 32'h0A);
    chk("s5_btn", 32'(bus.o_btn), 32'h01);

    // Long hold on button 4.
    bus.i_btn = 5'h10;
    longs = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.o_long[4]) longs++;
    end
`ifdef PBTN_LONGPRESS_EN
    chk("s6_long_count", 32'(longs), 32'd1);
`else
    chk("s6_long_count", 32'(longs), 32'd0);
`endif

    // Random bouncing with sporadic clears, and a reset landing mid-bounce.
    for (int b = 0; b < NB; b++) rem[b] = 0;
    for (int c = 0; c < 700; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (rem[b] == 0) begin
          bus.i_btn[b] = ~bus.i_btn[b];
          rem[b] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 45);
        end else begin
          rem[b]--;
        end
      end
      bus.i_event_clr = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
      if (c == 350) do_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
